match_ctrl: RTL
===============

// Module: match_ctrl
// PURPOSE
//  Match sequencer for the pong ball datapath: drives the ball's reset, entropy and speed inputs,
//  watches its out_left/out_right flags, keeps score and ends the game at WIN_SCORE.
//  Sits between the ball block and the score display/start button. Runs on clk; all timing uses
//  the 1-cycle tick enable (2 kHz ball rate).
// PARAMETERS
//  SERVE_TICKS  1000  ticks ball is held centred (ball_reset high) before each serve
//  PAUSE_TICKS  1000  ticks ball is frozen (speed 0) after a point
//  RAMP_TICKS   4000  rally ticks between +1 speed increments
//  SPEED_INIT   4     rally start speed (signed 5-bit, 1..15)
//  SPEED_MAX    15    speed ceiling (SPEED_INIT <= SPEED_MAX <= 15)
//  WIN_SCORE    9     score that ends the game (1..15)
// PORTS
//  clk          in   1  clock
//  reset        in   1  synchronous, active-high
//  tick         in   1  1-cycle enable at ball rate
//  start        in   1  start/restart request, level, sampled on clk
//  out_left     in   1  from ball: ball hit far-left edge (right player scores)
//  out_right    in   1  from ball: ball hit far-right edge (left player scores)
//  ball_reset   out  1  to ball reset: recentres ball, loads ball_entropy
//  ball_entropy out  5  to ball entropy
//  ball_speed   out  5  signed, to ball speed
//  score_l      out  4  left player score
//  score_r      out  4  right player score
//  state        out  3  IDLE=0 SERVE=1 RALLY=2 POINT=3 OVER=4
//  winner       out  1  valid in OVER: 0=left, 1=right
// BEHAVIOUR
//  - Reset: state=IDLE, ball_reset=1, ball_speed=0, scores=0, winner=0, counters=0, LFSR=5'b00001.
//  - All outputs registered; an input sampled at edge N takes effect on outputs after edge N.
//  - LFSR: 5-bit Fibonacci x^5+x^3+1, steps every clk (not tick); never zero.
//  - IDLE: ball_reset=1, speed 0. start=1 -> SERVE, scores cleared.
//  - SERVE (entry): ball_entropy <= LFSR value; tick counter=0. ball_reset=1, speed 0.
//    After SERVE_TICKS ticks -> RALLY; ball_reset=0, ball_speed=SPEED_INIT, ramp counter=0.
//  - RALLY: each tick increments ramp counter; at RAMP_TICKS -> counter=0,
//    ball_speed+1 saturating at SPEED_MAX (never wraps negative).
//    out_left -> score_r+1; out_right -> score_l+1; both same cycle -> out_left wins
//    (score_r only). Scoring edge -> POINT, ball_speed=0, ball_reset stays 0.
//    out_* outside RALLY ignored. start ignored outside IDLE/OVER.
//  - POINT: ball frozen for PAUSE_TICKS ticks. Then if score_l or score_r == WIN_SCORE -> OVER,
//    winner = (score_r==WIN_SCORE); else -> SERVE.
//  - OVER: ball_reset=1, speed 0, scores held. start=1 -> SERVE with scores cleared, winner=0.
//  - Score counters 4-bit, cannot exceed WIN_SCORE (game ends first).
//  - Tick counters count only on tick; a tick on the transition edge is not counted in the
//    new state. Counters are 16-bit; a count of 0 is treated as 1.
//  - reset wins over every other input in any state, mid-rally included.
// STRUCTURE
//  - pong_pkg: state enum (3-bit codes above), SCORE_W=4, SPEED_W=5, LFSR taps/seed constants.
//  - Sub-module lfsr5 (clk, reset, q[4:0]); rest is one FSM plus tick/ramp counters in match_ctrl.
// TESTING (SERVE_TICKS=4, PAUSE_TICKS=3, RAMP_TICKS=2, SPEED_INIT=4, SPEED_MAX=6, WIN_SCORE=2; tick every cycle)
//  - Reset then start=1 one cycle -> SERVE; ball_reset=1 for 4 ticks; then RALLY, ball_reset=0,
//    speed=4; ball_entropy equals LFSR sample at SERVE entry.
//  - Hold RALLY 10 ticks -> speed 4,5,6 then stays 6 (saturates, never negative).
//  - out_left pulse in RALLY -> score_r=1, POINT, speed 0 for 3 ticks, then SERVE again.
//  - out_left and out_right same cycle -> score_r+1 only, score_l unchanged.
//  - Two right-player points -> OVER, winner=1, score_r=2. out_* ignored; start -> SERVE, scores 0.
//  - reset asserted mid-RALLY at speed 5 -> next cycle IDLE, speed 0, scores 0, ball_reset=1.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match sequencer.
// State codes are fixed because the score display decodes them.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_RALLY = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int SCORE_W = 4;
  localparam int SPEED_W = 5;
  localparam int LFSR_W  = 5;
  localparam int CNT_W   = 16;

  // x^5 + x^3 + 1: feedback from bits 4 and 2
  localparam logic [LFSR_W-1:0] LFSR_SEED = 5'b00001;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 5'b10100;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] q
  );
    return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

  // A zero-length period behaves as one tick
  function automatic logic [CNT_W-1:0] cnt_lim(input int p);
    logic [31:0] v;
    v = p;
    return (p <= 0) ? 16'd1 : v[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/match_ctrl_if.sv
// Bundle between the match sequencer and its neighbours
// (ball block, start button, score display).
import pong_pkg::*;

interface match_ctrl_if;
  logic                      tick;
  logic                      start;
  logic                      out_left;
  logic                      out_right;
  logic                      ball_reset;
  logic [LFSR_W-1:0]         ball_entropy;
  logic signed [SPEED_W-1:0] ball_speed;
  logic [SCORE_W-1:0]        score_l;
  logic [SCORE_W-1:0]        score_r;
  logic [2:0]                state;
  logic                      winner;

  modport master (
    output tick, start, out_left, out_right,
    input  ball_reset, ball_entropy, ball_speed,
    input  score_l, score_r, state, winner
  );

  modport slave (
    input  tick, start, out_left, out_right,
    output ball_reset, ball_entropy, ball_speed,
    output score_l, score_r, state, winner
  );
endinterface

// File: rtl/lfsr5.sv
// Free-running 5-bit Fibonacci LFSR used as serve entropy.
// Seeded non-zero, so the all-zero lock-up state is unreachable.
import pong_pkg::*;

module lfsr5 (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= LFSR_SEED;
    else       q <= lfsr_next(q);
  end

endmodule

// File: rtl/match_ctrl.sv
// Match sequencer: serve, rally with speed ramp, point pause,
// scoring and game over for the pong ball datapath.
import pong_pkg::*;

module match_ctrl #(
  parameter int SERVE_TICKS = 1000,
  parameter int PAUSE_TICKS = 1000,
  parameter int RAMP_TICKS  = 4000,
  parameter int SPEED_INIT  = 4,
  parameter int SPEED_MAX   = 15,
  parameter int WIN_SCORE   = 9
) (
  input  logic         clk,
  input  logic         reset,
  match_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] SERVE_LIM = cnt_lim(SERVE_TICKS);
  localparam logic [CNT_W-1:0] PAUSE_LIM = cnt_lim(PAUSE_TICKS);
  localparam logic [CNT_W-1:0] RAMP_LIM  = cnt_lim(RAMP_TICKS);

  localparam logic [31:0] INIT_V = SPEED_INIT;
  localparam logic [31:0] MAX_V  = SPEED_MAX;
  localparam logic [31:0] WIN_V  = WIN_SCORE;

  localparam logic signed [SPEED_W-1:0] S_INIT = INIT_V[SPEED_W-1:0];
  localparam logic signed [SPEED_W-1:0] S_MAX  = MAX_V[SPEED_W-1:0];
  localparam logic [SCORE_W-1:0]        S_WIN  = WIN_V[SCORE_W-1:0];

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          ramp_q, ramp_d;
  logic signed [SPEED_W-1:0] speed_q, speed_d;
  logic                      brst_q, brst_d;
  logic [LFSR_W-1:0]         ent_q, ent_d;
  logic [SCORE_W-1:0]        sl_q, sl_d;
  logic [SCORE_W-1:0]        sr_q, sr_d;
  logic                      win_q, win_d;
  logic [LFSR_W-1:0]         lfsr_q;
  logic [CNT_W-1:0]          cnt_inc;
  logic [CNT_W-1:0]          ramp_inc;

  lfsr5 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign cnt_inc  = cnt_q + 16'd1;
  assign ramp_inc = ramp_q + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ramp_q  <= '0;
      speed_q <= '0;
      brst_q  <= 1'b1;
      ent_q   <= '0;
      sl_q    <= '0;
      sr_q    <= '0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ramp_q  <= ramp_d;
      speed_q <= speed_d;
      brst_q  <= brst_d;
      ent_q   <= ent_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ramp_d  = ramp_q;
    speed_d = speed_q;
    brst_d  = brst_q;
    ent_d   = ent_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    win_d   = win_q;

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.start) begin
          state_d = ST_SERVE;
          cnt_d   = '0;
          ent_d   = lfsr_q;
          brst_d  = 1'b1;
          speed_d = '0;
          sl_d    = '0;
          sr_d    = '0;
          win_d   = 1'b0;
        end
      end

      ST_SERVE: begin
        if (bus.tick) begin
          if (cnt_inc >= SERVE_LIM) begin
            state_d = ST_RALLY;
            brst_d  = 1'b0;
            speed_d = S_INIT;
            ramp_d  = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      ST_RALLY: begin
        // Left exit has priority when both flags fire together
        if (bus.out_left) begin
          state_d = ST_POINT;
          sr_d    = sr_q + 4'd1;
          speed_d = '0;
          cnt_d   = '0;
        end else if (bus.out_right) begin
          state_d = ST_POINT;
          sl_d    = sl_q + 4'd1;
          speed_d = '0;
          cnt_d   = '0;
        end else if (bus.tick) begin
          if (ramp_inc >= RAMP_LIM) begin
            ramp_d = '0;
            if (speed_q < S_MAX) speed_d = speed_q + 5'sd1;
          end else begin
            ramp_d = ramp_inc;
          end
        end
      end

      ST_POINT: begin
        if (bus.tick) begin
          if (cnt_inc >= PAUSE_LIM) begin
            cnt_d  = '0;
            brst_d = 1'b1;
            if (sl_q == S_WIN || sr_q == S_WIN) begin
              state_d = ST_OVER;
              win_d   = (sr_q == S_WIN);
            end else begin
              state_d = ST_SERVE;
              ent_d   = lfsr_q;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        brst_d  = 1'b1;
        speed_d = '0;
      end
    endcase
  end

  assign bus.ball_reset   = brst_q;
  assign bus.ball_entropy = ent_q;
  assign bus.ball_speed   = speed_q;
  assign bus.score_l      = sl_q;
  assign bus.score_r      = sr_q;
  assign bus.state        = state_q;
  assign bus.winner       = win_q;

endmodule
